// File: rtl/common_pkg.sv
// Shared fetch-side types and constants: instruction bus structs, the reset PC
// and the fetch buffer FSM state encoding.
package common_pkg;

    localparam logic [63:0] PCINIT = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fb_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: sequential fetch with one outstanding bus request,
// feeding a DEPTH-entry FIFO of {pc, instr}; redirect flushes and restarts.
module fetch_buffer
    import common_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = PCINIT
) (
    input  logic                    clk,
    input  logic                    reset,
    output ibus_req_t               ireq,
    input  ibus_resp_t              iresp,
    input  logic                    redirect,
    input  logic [63:0]             redirect_pc,
    // Consumer handshake: an entry transfers on any cycle with out_valid &&
    // out_ready; out_valid/out_pc/out_instr never depend on out_ready.
    output logic                    out_valid,
    output logic [63:0]             out_pc,
    output logic [31:0]             out_instr,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  count,
    output fb_state_t               fsm_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [63:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    fb_state_t     state;
    fb_state_t     state_next;
    logic [63:0]   fetch_pc;
    logic [63:0]   fetch_pc_next;
    logic [63:0]   drop_addr;

    logic          full;
    logic          issue;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_after;
    logic          unused_bits;

    assign full        = (count == CW'(DEPTH));
    // A request may start straight out of IDLE in the same cycle it is decided.
    assign issue       = (state == IDLE) && !full && !redirect && !reset;
    assign push        = (issue || (state == REQ)) && iresp.data_ok && !redirect;
    assign pop         = out_valid && out_ready && !redirect;
    assign count_after = count + CW'(push) - CW'(pop);
    assign unused_bits = ^{iresp.addr_ok, redirect_pc[1:0]};

    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? pc_mem[rd_ptr] : '0;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
    assign fsm_state = state;

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        ireq.valid    = issue || (!reset && (state != IDLE));
        ireq.addr     = (state == DROP) ? drop_addr : fetch_pc;

        case (state)
            IDLE: begin
                if (redirect)
                    state_next = REQ;
                else if (issue)
                    state_next = (push && (count_after == CW'(DEPTH))) ? IDLE : REQ;
            end
            REQ: begin
                if (redirect)
                    state_next = iresp.data_ok ? REQ : DROP;
                else if (push)
                    state_next = (count_after < CW'(DEPTH)) ? REQ : IDLE;
            end
            DROP: begin
                if (iresp.data_ok)
                    state_next = REQ;
            end
            default: state_next = IDLE;
        endcase

        if (redirect)
            fetch_pc_next = {redirect_pc[63:2], 2'b00};
        else if (push)
            fetch_pc_next = fetch_pc + 64'd4;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            drop_addr <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            // The abandoned request must keep its address on the bus until data_ok.
            if ((state == REQ) && redirect && !iresp.data_ok)
                drop_addr <= fetch_pc;
            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count_after;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= iresp.data;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed and randomized checks of fetch_buffer against a behavioural
// instruction memory with programmable response latency.
module tb_fetch_buffer;
    import common_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;
    logic [2:0]  count;
    fb_state_t   fsm_state;

    int tests_run = 0;
    int tests_failed = 0;

    int   bus_lat_fixed = 0;
    logic bus_rand = 1'b0;
    int   rand_lat = 0;
    int   bus_wait = 0;

    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(PCINIT)) dut (
        .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_ready(out_ready), .count(count), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0013;
    endfunction

    // Memory model: data_ok arrives after `latency` extra cycles of valid.
    always @(posedge clk) begin
        if (reset || !ireq.valid || iresp.data_ok) bus_wait <= 0;
        else bus_wait <= bus_wait + 1;
        if (iresp.data_ok) rand_lat <= $urandom_range(0, 5);
    end

    always_comb begin
        iresp.addr_ok = ireq.valid;
        iresp.data_ok = ireq.valid && (bus_wait == (bus_rand ? rand_lat : bus_lat_fixed));
        iresp.data    = mem_word(ireq.addr);
    end

    task automatic do_reset();
        reset = 1'b1;
        redirect = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        bus_lat_fixed = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", count); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests_run++; if (out_pc !== 64'h0) begin tests_failed++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
        tests_run++; if (out_instr !== 32'h0) begin tests_failed++; $display("FAIL reset_out_instr: got %h expected 0", out_instr); end
        tests_run++; if (ireq.valid !== 1'b0) begin tests_failed++; $display("FAIL reset_ireq_valid: got %b expected 0", ireq.valid); end
        tests_run++; if (fsm_state !== IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, IDLE); end
        reset = 1'b0;
        #1;
        tests_run++; if (ireq.valid !== 1'b1) begin tests_failed++; $display("FAIL first_req_valid: got %b expected 1", ireq.valid); end
        tests_run++; if (ireq.addr !== 64'h8000_0000) begin tests_failed++; $display("FAIL first_req_addr: got %h expected 80000000", ireq.addr); end
    endtask

    task automatic test_sequential();
        logic [63:0] exp_pc;
        out_ready = 1'b1;
        bus_lat_fixed = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_pc = 64'h8000_0000 + 64'(4 * i);
            tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, out_valid); end
            tests_run++; if (out_pc !== exp_pc) begin tests_failed++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, out_pc, exp_pc); end
            tests_run++; if (out_instr !== mem_word(exp_pc)) begin tests_failed++; $display("FAIL seq_instr[%0d]: got %h expected %h", i, out_instr, mem_word(exp_pc)); end
            tests_run++; if (count !== 3'd1) begin tests_failed++; $display("FAIL seq_count[%0d]: got %0d expected 1", i, count); end
        end
    endtask

    task automatic test_full();
        logic [63:0] exp_pc;
        out_ready = 1'b0;
        bus_lat_fixed = 0;
        do_reset();
        repeat (6) @(negedge clk);
        tests_run++; if (count !== 3'd4) begin tests_failed++; $display("FAIL full_count: got %0d expected 4", count); end
        tests_run++; if (ireq.valid !== 1'b0) begin tests_failed++; $display("FAIL full_ireq_valid: got %b expected 0", ireq.valid); end
        tests_run++; if (fsm_state !== IDLE) begin tests_failed++; $display("FAIL full_state: got %0d expected %0d", fsm_state, IDLE); end
        tests_run++; if (out_pc !== 64'h8000_0000) begin tests_failed++; $display("FAIL full_head: got %h expected 80000000", out_pc); end
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            exp_pc = 64'h8000_0000 + 64'(4 * i);
            tests_run++; if (out_valid !== 1'b1 || out_pc !== exp_pc) begin tests_failed++; $display("FAIL resume_pc[%0d]: got %b/%h expected 1/%h", i, out_valid, out_pc, exp_pc); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_redirect_idle();
        out_ready = 1'b0;
        bus_lat_fixed = 0;
        do_reset();
        repeat (6) @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 64'h8000_5000;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        tests_run++; if (count !== 3'd0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_redir_flush: got count %0d valid %b expected 0/0", count, out_valid); end
        tests_run++; if (fsm_state !== REQ) begin tests_failed++; $display("FAIL idle_redir_state: got %0d expected %0d", fsm_state, REQ); end
        tests_run++; if (ireq.addr !== 64'h8000_5000) begin tests_failed++; $display("FAIL idle_redir_addr: got %h expected 80005000", ireq.addr); end
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_5000) begin tests_failed++; $display("FAIL idle_redir_out: got %b/%h expected 1/80005000", out_valid, out_pc); end
    endtask

    task automatic test_redirect_drop();
        bit seen;
        out_ready = 1'b1;
        bus_lat_fixed = 0;
        do_reset();
        repeat (2) @(negedge clk);
        tests_run++; if (ireq.addr !== 64'h8000_0008) begin tests_failed++; $display("FAIL drop_setup_addr: got %h expected 80000008", ireq.addr); end
        bus_lat_fixed = 3;
        redirect = 1'b1;
        redirect_pc = 64'h8000_1000;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        tests_run++; if (fsm_state !== DROP) begin tests_failed++; $display("FAIL drop_state: got %0d expected %0d", fsm_state, DROP); end
        tests_run++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0008) begin tests_failed++; $display("FAIL drop_hold: got %b/%h expected 1/80000008", ireq.valid, ireq.addr); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL drop_flush: got %b expected 0", out_valid); end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (fsm_state == DROP) begin
                tests_run++; if (ireq.addr !== 64'h8000_0008) begin tests_failed++; $display("FAIL drop_addr_stable: got %h expected 80000008", ireq.addr); end
            end
            if (out_valid) seen = 1;
        end
        tests_run++; if (!seen) begin tests_failed++; $display("FAIL drop_timeout: got no out_valid expected one within 20 cycles"); end
        tests_run++; if (out_pc !== 64'h8000_1000) begin tests_failed++; $display("FAIL drop_first_pc: got %h expected 80001000", out_pc); end
        tests_run++; if (out_instr !== mem_word(64'h8000_1000)) begin tests_failed++; $display("FAIL drop_first_instr: got %h expected %h", out_instr, mem_word(64'h8000_1000)); end
        bus_lat_fixed = 0;
    endtask

    task automatic test_redirect_coincident();
        out_ready = 1'b1;
        bus_lat_fixed = 0;
        do_reset();
        repeat (2) @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 64'h8000_3000;
        #1;
        tests_run++; if ((ireq.valid && iresp.data_ok && out_valid) !== 1'b1) begin tests_failed++; $display("FAIL coinc_setup: got %b%b%b expected 111", ireq.valid, iresp.data_ok, out_valid); end
        @(negedge clk);
        redirect = 1'b0;
        #1;
        tests_run++; if (count !== 3'd0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL coinc_flush: got count %0d valid %b expected 0/0", count, out_valid); end
        tests_run++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_3000) begin tests_failed++; $display("FAIL coinc_addr: got %b/%h expected 1/80003000", ireq.valid, ireq.addr); end
        @(negedge clk);
        tests_run++; if (out_pc !== 64'h8000_3000 || count !== 3'd1) begin tests_failed++; $display("FAIL coinc_out: got %h count %0d expected 80003000 count 1", out_pc, count); end
    endtask

    task automatic test_align_wrap();
        out_ready = 1'b1;
        bus_lat_fixed = 0;
        do_reset();
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 64'h8000_2003;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        tests_run++; if (ireq.addr !== 64'h8000_2000) begin tests_failed++; $display("FAIL align_addr: got %h expected 80002000", ireq.addr); end
        @(negedge clk);
        tests_run++; if (out_pc !== 64'h8000_2000) begin tests_failed++; $display("FAIL align_out: got %h expected 80002000", out_pc); end
        redirect = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        tests_run++; if (ireq.addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin tests_failed++; $display("FAIL wrap_top: got %h expected fffffffffffffffc", ireq.addr); end
        @(negedge clk);
        tests_run++; if (ireq.addr !== 64'h0) begin tests_failed++; $display("FAIL wrap_next: got %h expected 0", ireq.addr); end
        tests_run++; if (out_pc !== 64'hFFFF_FFFF_FFFF_FFFC || out_instr !== mem_word(64'hFFFF_FFFF_FFFF_FFFC)) begin tests_failed++; $display("FAIL wrap_out: got %h/%h expected fffffffffffffffc/%h", out_pc, out_instr, mem_word(64'hFFFF_FFFF_FFFF_FFFC)); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        bus_lat_fixed = 5;
        do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests_run++; if (ireq.valid !== 1'b0) begin tests_failed++; $display("FAIL midreset_valid: got %b expected 0", ireq.valid); end
        @(negedge clk);
        tests_run++; if (fsm_state !== IDLE || count !== 3'd0) begin tests_failed++; $display("FAIL midreset_state: got %0d count %0d expected %0d count 0", fsm_state, count, IDLE); end
        reset = 1'b0;
        #1;
        tests_run++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0000) begin tests_failed++; $display("FAIL midreset_restart: got %b/%h expected 1/80000000", ireq.valid, ireq.addr); end
        bus_lat_fixed = 0;
    endtask

    task automatic test_random();
        logic [63:0] exp_head;
        logic [63:0] prev_addr;
        logic        prev_pending;
        bus_rand = 1'b1;
        out_ready = 1'b0;
        do_reset();
        exp_head = PCINIT;
        prev_pending = 1'b0;
        prev_addr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (prev_pending) begin
                tests_run++; if (ireq.valid !== 1'b1 || ireq.addr !== prev_addr) begin tests_failed++; $display("FAIL rnd_req_stable@%0d: got %b/%h expected 1/%h", cyc, ireq.valid, ireq.addr, prev_addr); end
            end
            tests_run++; if (count > 3'(DEPTH)) begin tests_failed++; $display("FAIL rnd_count@%0d: got %0d expected <= %0d", cyc, count, DEPTH); end
            if (out_valid) begin
                tests_run++; if (out_pc !== exp_head || out_instr !== mem_word(exp_head)) begin tests_failed++; $display("FAIL rnd_head@%0d: got %h/%h expected %h/%h", cyc, out_pc, out_instr, exp_head, mem_word(exp_head)); end
            end
            redirect  = ($urandom_range(0, 99) < 3);
            out_ready = 1'($urandom_range(0, 1));
            if (redirect) begin
                redirect_pc = {32'h0, $urandom};
                exp_head = {redirect_pc[63:2], 2'b00};
            end else if (out_valid && out_ready) begin
                exp_head = exp_head + 64'd4;
            end
            #1;
            prev_pending = ireq.valid && !iresp.data_ok;
            prev_addr = ireq.addr;
        end
        redirect = 1'b0;
        out_ready = 1'b0;
        bus_rand = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1000000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sequential();
        test_full();
        test_redirect_idle();
        test_redirect_drop();
        test_redirect_coincident();
        test_align_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
